// File: rtl/wb_pkg.sv
// Shared types and helpers for the pipelined Wishbone B4 slave blocks.
package wb_pkg;

  // Control half of a pipelined response; the data half is sized by each user.
  typedef struct packed {
    logic valid;
    logic err;
  } wb_resp_ctl_t;

  localparam int unsigned LatencyMax     = 8;
  localparam int unsigned OutstandingMax = 8;

  // One byte lane of a byte-enabled write merge.
  function automatic logic [7:0] wb_merge_byte(input logic [7:0] old_b,
                                               input logic [7:0] new_b,
                                               input logic       en);
    return en ? new_b : old_b;
  endfunction

endpackage

// File: rtl/wb_resp_pipe.sv
// Fixed-latency response shift register with synchronous flush.
module wb_resp_pipe
  import wb_pkg::*;
#(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Latency   = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 push_valid_i,
  input  logic                 push_err_i,
  input  logic [DataWidth-1:0] push_data_i,
  output logic                 pop_valid_o,
  output logic                 pop_err_o,
  output logic [DataWidth-1:0] pop_data_o
);

  typedef struct packed {
    wb_resp_ctl_t         ctl;
    logic [DataWidth-1:0] data;
  } resp_t;

  resp_t stage_q [Latency];
  resp_t push_entry;

  always_comb begin
    push_entry           = '0;
    push_entry.ctl.valid = push_valid_i;
    push_entry.ctl.err   = push_err_i;
    push_entry.data      = push_data_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its predecessor's pre-edge value and the chain shifts by one.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      for (int i = 0; i < Latency; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= push_entry;
      for (int i = 1; i < Latency; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign pop_valid_o = stage_q[Latency-1].ctl.valid;
  assign pop_err_o   = stage_q[Latency-1].ctl.err;
  assign pop_data_o  = stage_q[Latency-1].data;

endmodule

// File: rtl/wb_mem_slave.sv
// Pipelined Wishbone B4 slave fronting a word-addressed RAM with fixed-latency
// ack/err, an in-flight limit, and response discard when the master drops CYC.
module wb_mem_slave
  import wb_pkg::*;
#(
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned AddrWidth      = 30,
  parameter int unsigned Depth          = 1024,
  parameter int unsigned Latency        = 2,
  parameter int unsigned MaxOutstanding = 2,
  localparam int unsigned SelWidth      = DataWidth / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wb_cyc_i,
  input  logic                 wb_stb_i,
  input  logic                 wb_we_i,
  input  logic [AddrWidth-1:0] wb_addr_i,
  input  logic [SelWidth-1:0]  wb_sel_i,
  input  logic [DataWidth-1:0] wb_data_i,
  output logic [DataWidth-1:0] wb_data_o,
  output logic                 wb_ack_o,
  output logic                 wb_err_o,
  output logic                 wb_stall_o
);

  localparam int unsigned IdxWidth = $clog2(Depth);
  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);

  // NOTE: the RAM has no reset; clearing it would forbid block-RAM inference
  // and contents are allowed to survive a bus reset.
  logic [DataWidth-1:0] mem [Depth];

  logic [CntWidth-1:0]  outstanding_q;
  logic                 accept;
  logic                 in_range;
  logic [IdxWidth-1:0]  idx;
  logic [DataWidth-1:0] rd_word;
  logic [DataWidth-1:0] wr_word;
  logic                 push_err;
  logic [DataWidth-1:0] push_data;
  logic                 pop_valid;
  logic                 pop_err;
  logic [DataWidth-1:0] pop_data;
  logic                 emit;

  // Stall is a pure function of registered state, never of the bus inputs.
  assign wb_stall_o = (outstanding_q == CntWidth'(MaxOutstanding));
  assign accept     = wb_cyc_i && wb_stb_i && !wb_stall_o;

  assign in_range = ((wb_addr_i >> IdxWidth) == '0);
  assign idx      = wb_addr_i[IdxWidth-1:0];
  assign rd_word  = mem[idx];

  // NOTE: every always_comb output gets a default first, so no path through
  // the block can leave a value held and infer a latch.
  always_comb begin
    wr_word = rd_word;
    for (int k = 0; k < SelWidth; k++) begin
      wr_word[8*k +: 8] = wb_merge_byte(rd_word[8*k +: 8], wb_data_i[8*k +: 8],
                                        wb_sel_i[k]);
    end
  end

  always_comb begin
    push_err  = !in_range;
    push_data = '0;
    if (accept && !wb_we_i && in_range) push_data = rd_word;
  end

  // Writes commit at acceptance, so a later read always observes them.
  always_ff @(posedge clk_i) begin
    if (accept && wb_we_i && in_range) mem[idx] <= wr_word;
  end

  wb_resp_pipe #(
    .DataWidth (DataWidth),
    .Latency   (Latency)
  ) u_resp_pipe (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (!wb_cyc_i),
    .push_valid_i (accept),
    .push_err_i   (push_err),
    .push_data_i  (push_data),
    .pop_valid_o  (pop_valid),
    .pop_err_o    (pop_err),
    .pop_data_o   (pop_data)
  );

  // A response surfacing while CYC is low belongs to an aborted cycle.
  assign emit      = pop_valid && wb_cyc_i;
  assign wb_ack_o  = emit && !pop_err;
  assign wb_err_o  = emit && pop_err;
  assign wb_data_o = wb_ack_o ? pop_data : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i || !wb_cyc_i) begin
      outstanding_q <= '0;
    end else begin
      case ({accept, emit})
        2'b10:   outstanding_q <= outstanding_q + CntWidth'(1);
        2'b01:   outstanding_q <= outstanding_q - CntWidth'(1);
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

endmodule
